// File: rtl/button_bank.sv
// button_bank: bank of debounced push-button interpreters for the clock front
// panel. Each channel synchronises an active-low raw key, debounces it with a
// stable-count filter and turns the clean level into single-cycle press,
// release, long-press and auto-repeat events plus a "held" level.
//
// Optional feature: define BUTTON_BANK_AUTOREPEAT_EN to build the auto-repeat
// generator. Without it repeat_o is tied low and no repeat logic exists.

// One key channel: synchroniser -> debouncer -> event FSM.
module button_bank_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 500,
    parameter int REPEAT_CYCLES   = 100
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic key_ni,
    input  logic en_i,
    output logic pressed_o,
    output logic released_o,
    output logic long_o,
    output logic held_o,
    output logic repeat_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Last count value before the threshold is reached on the following edge.
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BUTTON_BANK_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } state_e;

    // Synchroniser and debouncer state.
    logic [1:0]      sync_q;
    logic            db_q;
    logic            db_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            db_fall;
    logic            db_rise;

    // Event FSM state; one counter serves as hold timer in DOWN and as
    // repeat timer in LONG, since the two phases never overlap.
    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            pressed_q;
    logic            released_q;
    logic            long_q;
    logic            held_q;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
    logic            repeat_q;
`endif

    // Two-flop synchroniser; resets to the released level (1) so a key held
    // through reset is seen as a fresh press.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_ni};
        end
    end

    // Debouncer next state: count consecutive samples that disagree with the
    // accepted level; toggle the level when the run reaches DEBOUNCE_CYCLES.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        db_fall  = 1'b0;
        db_rise  = 1'b0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d    = ~db_q;
                db_fall = db_q;
                db_rise = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debouncer registers; they keep running even while the channel is
    // disabled so the level is correct the moment it is re-enabled.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            db_q     <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Event FSM: reacts on the same edge the debounced level changes, so the
    // event pulse is visible in the cycle right after that edge.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
            repeat_q   <= 1'b0;
`endif
        end else begin
            // Pulses are low unless a branch below raises one.
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
            repeat_q   <= 1'b0;
`endif
            if (!en_i) begin
                // Disabled: silently drop to IDLE, no release event.
                state_q <= IDLE;
                cnt_q   <= '0;
                held_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Only a fresh falling edge starts a press; a key
                        // already down when re-enabled is ignored.
                        if (db_fall) begin
                            state_q   <= DOWN;
                            cnt_q     <= '0;
                            pressed_q <= 1'b1;
                        end
                    end
                    DOWN: begin
                        // Release takes priority over the hold threshold.
                        if (db_rise) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            released_q <= 1'b1;
                        end else if (cnt_q >= HOLD_LAST) begin
                            state_q <= LONG;
                            cnt_q   <= '0;
                            long_q  <= 1'b1;
                            held_q  <= 1'b1;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                            repeat_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    LONG: begin
                        if (db_rise) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            released_q <= 1'b1;
                            held_q     <= 1'b0;
                        end
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                        // Repeat timer reloads on every pulse; the >= compare
                        // also keeps it from ever wrapping.
                        else if (cnt_q >= REP_LAST) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pressed_o  = pressed_q;
    assign released_o = released_q;
    assign long_o     = long_q;
    assign held_o     = held_q;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
    assign repeat_o   = repeat_q;
`else
    assign repeat_o   = 1'b0;
`endif

endmodule

// Top level: CHANNELS fully independent key channels.
module button_bank #(
    parameter int CHANNELS        = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 500,
    parameter int REPEAT_CYCLES   = 100
) (
    input  logic                clk_i,
    input  logic                nreset_i,
    input  logic [CHANNELS-1:0] keys_ni,
    input  logic [CHANNELS-1:0] chan_en_i,
    output logic [CHANNELS-1:0] pressed_o,
    output logic [CHANNELS-1:0] released_o,
    output logic [CHANNELS-1:0] long_o,
    output logic [CHANNELS-1:0] held_o,
    output logic [CHANNELS-1:0] repeat_o
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        button_bank_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk_i      (clk_i),
            .nreset_i   (nreset_i),
            .key_ni     (keys_ni[ch]),
            .en_i       (chan_en_i[ch]),
            .pressed_o  (pressed_o[ch]),
            .released_o (released_o[ch]),
            .long_o     (long_o[ch]),
            .held_o     (held_o[ch]),
            .repeat_o   (repeat_o[ch])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Testbench for button_bank: randomised key activity checked cycle by cycle
// against a timestamp-based reference model through a scoreboard queue.
module tb_button_bank;

    localparam int C = 3;
    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 5;

    typedef struct packed {
        logic [C-1:0] p;
        logic [C-1:0] r;
        logic [C-1:0] l;
        logic [C-1:0] h;
        logic [C-1:0] rp;
    } exp_t;

    logic         clk;
    logic         nreset;
    logic [C-1:0] keys_n;
    logic [C-1:0] chan_en;
    logic [C-1:0] pressed;
    logic [C-1:0] released;
    logic [C-1:0] long_p;
    logic [C-1:0] held;
    logic [C-1:0] rep;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    button_bank #(
        .CHANNELS        (C),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk_i      (clk),
        .nreset_i   (nreset),
        .keys_ni    (keys_n),
        .chan_en_i  (chan_en),
        .pressed_o  (pressed),
        .released_o (released),
        .long_o     (long_p),
        .held_o     (held),
        .repeat_o   (rep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [C-1:0] act, input logic [C-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", name, cycle, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Key history per channel: bit j is the raw key seen j edges ago. The
    // synchronised sample at an edge is the raw key from two edges earlier;
    // the debounced level flips when the last D such samples all disagree.
    bit [D+1:0] kh      [C];
    bit         db_m    [C];
    bit         act_m   [C];
    bit         lng_m   [C];
    int         press_e [C];
    int         long_e  [C];
    int         edge_n = 0;
    bit         all_diff;
    bit         fall_m;
    bit         rise_m;
    exp_t       mdl_e;
    exp_t       q[$];

    always @(posedge clk) begin
        mdl_e = '0;
        if (!nreset) begin
            for (int c = 0; c < C; c++) begin
                kh[c]    = '1;
                db_m[c]  = 1'b1;
                act_m[c] = 1'b0;
                lng_m[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < C; c++) begin
                kh[c] = {kh[c][D:0], keys_n[c]};
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (kh[c][j] == db_m[c]) all_diff = 1'b0;
                fall_m = all_diff && db_m[c];
                rise_m = all_diff && !db_m[c];
                if (all_diff) db_m[c] = !db_m[c];

                if (!chan_en[c]) begin
                    act_m[c] = 1'b0;
                    lng_m[c] = 1'b0;
                end else if (!act_m[c]) begin
                    if (fall_m) begin
                        act_m[c]   = 1'b1;
                        press_e[c] = edge_n;
                        mdl_e.p[c] = 1'b1;
                    end
                end else if (rise_m) begin
                    act_m[c]   = 1'b0;
                    lng_m[c]   = 1'b0;
                    mdl_e.r[c] = 1'b1;
                end else if (!lng_m[c]) begin
                    if (edge_n - press_e[c] == H) begin
                        lng_m[c]   = 1'b1;
                        long_e[c]  = edge_n;
                        mdl_e.l[c] = 1'b1;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                        mdl_e.rp[c] = 1'b1;
`endif
                    end
                end else begin
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                    if ((edge_n - long_e[c]) % R == 0) mdl_e.rp[c] = 1'b1;
`endif
                end
                mdl_e.h[c] = lng_m[c];
            end
        end
        edge_n++;
        q.push_back(mdl_e);
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        cycle++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("pressed",  pressed,  mon_e.p);
            check("released", released, mon_e.r);
            check("long",     long_p,   mon_e.l);
            check("held",     held,     mon_e.h);
            check("repeat",   rep,      mon_e.rp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int seg [C];
    int pick;

    initial begin
        nreset  = 1'b0;
        keys_n  = '1;
        chan_en = '1;
        tick(3);
        nreset = 1'b1;
        tick(2);

        // Long press on channel 0 with repeats, then release.
        keys_n[0] = 1'b0; tick(35); keys_n[0] = 1'b1; tick(15);
        // Bounce shorter than the debounce window.
        keys_n[1] = 1'b0; tick(3);  keys_n[1] = 1'b1; tick(12);
        // Release lands exactly on the hold threshold, one before and one after.
        keys_n[1] = 1'b0; tick(H);     keys_n[1] = 1'b1; tick(15);
        keys_n[1] = 1'b0; tick(H - 1); keys_n[1] = 1'b1; tick(15);
        keys_n[1] = 1'b0; tick(H + 1); keys_n[1] = 1'b1; tick(15);

        // Simultaneous press, channel 2 disabled, then enabled mid-press.
        chan_en[2] = 1'b0;
        keys_n[0] = 1'b0; keys_n[2] = 1'b0; tick(12);
        chan_en[2] = 1'b1; tick(20);
        keys_n[0] = 1'b1; keys_n[2] = 1'b1; tick(15);
        keys_n[2] = 1'b0; tick(12); keys_n[2] = 1'b1; tick(15);

        // Disable while in long press, re-enable with key still down.
        keys_n[0] = 1'b0; tick(25);
        chan_en[0] = 1'b0; tick(3);
        chan_en[0] = 1'b1; tick(5);
        keys_n[0] = 1'b1; tick(15);

        // Asynchronous reset while channel 2 is in long press.
        keys_n[2] = 1'b0; tick(25);
        check("pre_rst_held", held, 3'b100);
        nreset = 1'b0;
        #1;
        check("rst_pressed",  pressed,  '0);
        check("rst_released", released, '0);
        check("rst_long",     long_p,   '0);
        check("rst_held",     held,     '0);
        check("rst_repeat",   rep,      '0);
        tick(2);
        nreset = 1'b1;
        tick(25);
        keys_n[2] = 1'b1; tick(15);

        // Randomised activity: per-channel segments of bounces and holds.
        for (int c = 0; c < C; c++) seg[c] = $urandom_range(1, 30);
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            for (int c = 0; c < C; c++) begin
                if (seg[c] == 0) begin
                    keys_n[c] = ~keys_n[c];
                    seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                         : $urandom_range(6, 40);
                end else begin
                    seg[c]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                pick = $urandom_range(0, C - 1);
                chan_en[pick] = ~chan_en[pick];
            end
            if (i == 1500) nreset = 1'b0;
            if (i == 1503) nreset = 1'b1;
        end

        keys_n  = '1;
        chan_en = '1;
        tick(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_bank.md
# button_bank

Parametrised bank of debounced push-button interpreters for the clock front panel. Each channel synchronises an active-low raw key, filters bounce with a stable-count debouncer, and emits single-cycle press, release, long-press and optional auto-repeat events. The bank sits between the board keys and the mode-routing logic that steers events to the clock, stopwatch and timer units.

## Interface
- CHANNELS, 3: number of independent key channels (>=1).
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change (>=1).
- HOLD_CYCLES, 500: cycles a debounced press must persist before a long press is declared (>=1).
- REPEAT_CYCLES, 100: auto-repeat period after a long press (>=1).
- clk_i  in  1  clock; all state updates on rising edge.
- nreset_i  in  1  reset, asynchronous, active-low.
- keys_ni  in  CHANNELS  raw keys, active-low (0 = pressed), asynchronous to clk_i.
- chan_en_i  in  CHANNELS  per-channel enable; 0 forces that channel idle.
- pressed_o  out  CHANNELS  one-cycle pulse on accepted press.
- released_o  out  CHANNELS  one-cycle pulse on accepted release.
- long_o  out  CHANNELS  one-cycle pulse when a press reaches HOLD_CYCLES.
- held_o  out  CHANNELS  level; high from long_o pulse until release.
- repeat_o  out  CHANNELS  one-cycle auto-repeat pulses (see Configuration).

## Operation
- Per channel: 2-flop synchroniser -> debouncer -> event FSM; channels fully independent, no shared counters.
- Debouncer: debounced level db (reset 1 = released). Counter increments each cycle the synchronised sample differs from db; clears on any cycle it equals db. When counter reaches DEBOUNCE_CYCLES, db toggles and counter clears. Counter width $clog2(DEBOUNCE_CYCLES+1).
- FSM states: IDLE, DOWN, LONG.
  - IDLE -> DOWN on db falling edge; pressed_o pulse.
  - DOWN: hold counter increments each cycle; at count HOLD_CYCLES -> LONG, long_o pulse, held_o set. db rising -> IDLE, released_o pulse.
  - LONG: repeat counter runs; db rising -> IDLE, released_o pulse, held_o cleared same cycle.
- Hold/repeat counters saturate, never wrap; width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1); cleared on entry to IDLE/DOWN.
- chan_en_i low: FSM forced to IDLE and counters cleared next edge, all outputs of that channel 0 (no released_o emitted); synchroniser and debouncer keep running. Re-enabling with key already down produces no pressed_o until a release and new press is debounced.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.

## Timing
- Reset: all outputs 0, db=1, FSM IDLE, all counters 0; asynchronous assert, outputs valid from first edge after deassert.
- Press latency: key low stable before edge k -> first sync flop captures at k, second at k+1, db falls at edge k+1+DEBOUNCE_CYCLES, pressed_o high for the cycle after that edge. Release latency identical.
- long_o exactly HOLD_CYCLES cycles after pressed_o; pressed_o, long_o, released_o never coincide on one channel.
- Release on the same edge as the hold count hits HOLD_CYCLES: release wins, no long_o.
- Reset mid-press: channel returns to IDLE; a key still down after reset yields pressed_o after normal debounce latency (db resets to released).

## Configuration
- BUTTON_BANK_AUTOREPEAT_EN defined: in LONG, repeat_o pulses in the same cycle as long_o, then every REPEAT_CYCLES cycles until release; repeat counter reloads on each pulse.
- Undefined: repeat_o tied 0, repeat counter and REPEAT_CYCLES logic not built; all other behaviour unchanged.

## Test plan
- DEBOUNCE_CYCLES=4: key 0 held from edge 0 -> pressed_o high after edge 5 only, low after edge 6; release likewise -> single released_o.
- Glitch: key low for 3 cycles then high -> no pressed_o/released_o, db stays 1.
- HOLD_CYCLES=10: press held 25 cycles -> long_o exactly 10 cycles after pressed_o, held_o high until released_o cycle.
- AUTOREPEAT_EN, REPEAT_CYCLES=5, hold 22 cycles past long_o -> repeat_o at offsets 0,5,10,15,20 from long_o; macro off -> repeat_o always 0.
- Channels 0 and 2 pressed simultaneously, chan_en_i[2]=0 -> only pressed_o[0]; raising chan_en_i[2] mid-press gives nothing until re-press.
- nreset_i pulsed low while key held in LONG -> outputs 0 immediately; pressed_o reappears 6 cycles after deassert (DEBOUNCE_CYCLES=4).
